// File: rtl/ram_responder_pkg.sv
// Shared encodings for the CPU memory handshake and the responder state machine.
package ram_responder_pkg;

   localparam logic [1:0] SIZE_BYTE  = 2'b00;
   localparam logic [1:0] SIZE_HALF  = 2'b01;
   localparam logic [1:0] SIZE_WORD  = 2'b10;
   localparam logic [1:0] SIZE_DWORD = 2'b11;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT1,
      ST_DONE1,
      ST_WAIT2,
      ST_DONE
   } resp_state_t;

   // True when the low address bits are not naturally aligned for the access size.
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
      case (size)
         SIZE_HALF:  misaligned = addr_lo[0];
         SIZE_WORD:  misaligned = |addr_lo[1:0];
         SIZE_DWORD: misaligned = |addr_lo;
         default:    misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ram_storage.sv
// Byte-wide storage viewed as big-endian 32-bit words: registered word read,
// byte-enabled word write. Contents are never reset.
module ram_storage #(
   parameter int ADDR_W    = 9,
   parameter int MEM_BYTES = 512
) (
   input  logic              clk,
   input  logic [ADDR_W-3:0] rd_word,
   output logic [31:0]       rd_data,
   input  logic              we,
   input  logic [ADDR_W-3:0] wr_word,
   input  logic [3:0]        be,
   input  logic [31:0]       wr_data
);

   logic [7:0] mem [MEM_BYTES];

   // Read the addressed word every cycle; byte 0 of the word lands in [31:24].
   always_ff @(posedge clk) begin
      rd_data <= {mem[{rd_word, 2'd0}], mem[{rd_word, 2'd1}],
                  mem[{rd_word, 2'd2}], mem[{rd_word, 2'd3}]};
   end

   // Commit enabled byte lanes; be[3] is the lowest byte address.
   always_ff @(posedge clk) begin
      if (we) begin
         if (be[3]) mem[{wr_word, 2'd0}] <= wr_data[31:24];
         if (be[2]) mem[{wr_word, 2'd1}] <= wr_data[23:16];
         if (be[1]) mem[{wr_word, 2'd2}] <= wr_data[15:8];
         if (be[0]) mem[{wr_word, 2'd3}] <= wr_data[7:0];
      end
   end

endmodule

// File: rtl/ram_responder.sv
// Responder end of the MFA/MFC memory handshake with byte/half/word/doubleword access.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for ramMFA; request fields latched on accept
//   ST_WAIT1 | latency countdown for the first (or only) beat
//   ST_DONE1 | one-cycle MFC pulse after doubleword beat 1; beat-2 data latched
//   ST_WAIT2 | latency countdown for doubleword beat 2 (addr+4)
//   ST_DONE  | MFC (and ramError) held until ramMFA is seen low
module ram_responder
   import ram_responder_pkg::*;
#(
   parameter int LATENCY   = 2,
   parameter int MEM_BYTES = 512,
   parameter int ADDR_W    = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ramMFA,
   input  logic              ramRW,
   input  logic [ADDR_W-1:0] ramAddress,
   input  logic [1:0]        ramDataSize,
   input  logic [31:0]       ramDataIn,
   output logic [31:0]       ramDataOut,
   output logic              ramMFC,
   output logic              ramError
);

   localparam int WI = ADDR_W - 2;
   localparam logic [3:0]    CNT_LOAD = 4'(LATENCY - 1);
   localparam logic [WI-1:0] ONE_W    = WI'(1);

   resp_state_t   state;
   logic [3:0]    cnt_q;
   logic          rw_q;
   logic [1:0]    size_q;
   logic [1:0]    off_q;
   logic [WI-1:0] word_q;
   logic [31:0]   din_q;
   logic          err_q;

   logic [WI-1:0] next_word;
   logic [WI-1:0] rd_word;
   logic [31:0]   rd_data;
   logic [31:0]   rd_steer;
   logic [31:0]   wr_data;
   logic [3:0]    be;
   logic          commit_edge;
   logic          we;

   assign next_word   = word_q + ONE_W;
   assign commit_edge = reset && ramMFA && (cnt_q == '0) &&
                        ((state == ST_WAIT1) || (state == ST_WAIT2));
   assign we          = commit_edge && (rw_q == RW_WRITE) && !err_q;

   // Storage read is registered, so present the address one cycle ahead of use.
   always_comb begin
      rd_word = word_q;
      if (state == ST_IDLE)       rd_word = ramAddress[ADDR_W-1:2];
      else if (state == ST_DONE1) rd_word = next_word;
   end

   // Pick the addressed lanes out of the big-endian word and zero-extend.
   always_comb begin
      rd_steer = rd_data;
      case (size_q)
         SIZE_BYTE: begin
            case (off_q)
               2'd0:    rd_steer = {24'd0, rd_data[31:24]};
               2'd1:    rd_steer = {24'd0, rd_data[23:16]};
               2'd2:    rd_steer = {24'd0, rd_data[15:8]};
               default: rd_steer = {24'd0, rd_data[7:0]};
            endcase
         end
         SIZE_HALF: rd_steer = off_q[1] ? {16'd0, rd_data[15:0]} : {16'd0, rd_data[31:16]};
         default:   rd_steer = rd_data;
      endcase
   end

   // Replicate narrow write data onto every lane and enable only the addressed ones.
   always_comb begin
      wr_data = din_q;
      be      = 4'b1111;
      case (size_q)
         SIZE_BYTE: begin
            wr_data = {4{din_q[7:0]}};
            be      = 4'b1000 >> off_q;
         end
         SIZE_HALF: begin
            wr_data = {2{din_q[15:0]}};
            be      = off_q[1] ? 4'b0011 : 4'b1100;
         end
         default: ;
      endcase
   end

   ram_storage #(
      .ADDR_W    (ADDR_W),
      .MEM_BYTES (MEM_BYTES)
   ) u_storage (
      .clk     (clk),
      .rd_word (rd_word),
      .rd_data (rd_data),
      .we      (we),
      .wr_word (word_q),
      .be      (be),
      .wr_data (wr_data)
   );

   // Handshake sequencing, latency down-counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt_q      <= '0;
         ramMFC     <= 1'b0;
         ramError   <= 1'b0;
         ramDataOut <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ramMFA) begin
                  rw_q   <= ramRW;
                  size_q <= ramDataSize;
                  off_q  <= ramAddress[1:0];
                  word_q <= ramAddress[ADDR_W-1:2];
                  din_q  <= ramDataIn;
                  err_q  <= misaligned(ramDataSize, ramAddress[2:0]);
                  cnt_q  <= CNT_LOAD;
                  state  <= ST_WAIT1;
               end
            end
            ST_WAIT1, ST_WAIT2: begin
               if (!ramMFA) begin
                  state <= ST_IDLE;
               end else if (cnt_q == '0) begin
                  ramMFC   <= 1'b1;
                  ramError <= err_q;
                  if (err_q)                ramDataOut <= '0;
                  else if (rw_q == RW_READ) ramDataOut <= rd_steer;
                  if ((state == ST_WAIT1) && (size_q == SIZE_DWORD) && !err_q)
                     state <= ST_DONE1;
                  else
                     state <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_DONE1: begin
               ramMFC <= 1'b0;
               if (!ramMFA) begin
                  state <= ST_IDLE;
               end else begin
                  word_q <= next_word;
                  din_q  <= ramDataIn;
                  cnt_q  <= CNT_LOAD;
                  state  <= ST_WAIT2;
               end
            end
            ST_DONE: begin
               if (!ramMFA) begin
                  ramMFC   <= 1'b0;
                  ramError <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: table of single accesses plus doubleword,
// abort, reset and handshake-hold sequences, checked through a scoreboard queue.
module tb_ram_responder;
   import ram_responder_pkg::*;

   localparam int LAT    = 2;
   localparam int ADDR_W = 9;
   localparam int BOUND  = 20;

   logic              clk = 1'b0;
   logic              reset;
   logic              ramMFA;
   logic              ramRW;
   logic [ADDR_W-1:0] ramAddress;
   logic [1:0]        ramDataSize;
   logic [31:0]       ramDataIn;
   logic [31:0]       ramDataOut;
   logic              ramMFC;
   logic              ramError;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        chk_data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        size;
      logic [31:0]       din;
      logic [31:0]       exp_data;
      logic              exp_err;
   } vec_t;
   vec_t vecs[14];

   ram_responder #(.LATENCY(LAT), .MEM_BYTES(512), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .ramMFA      (ramMFA),
      .ramRW       (ramRW),
      .ramAddress  (ramAddress),
      .ramDataSize (ramDataSize),
      .ramDataIn   (ramDataIn),
      .ramDataOut  (ramDataOut),
      .ramMFC      (ramMFC),
      .ramError    (ramError)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Wait for ramMFC to rise, counting edges; expect exactly LAT edges.
   task automatic wait_mfc(input string name);
      int n;
      logic got;
      n = 0;
      got = 1'b0;
      while (n < BOUND && !got) begin
         @(posedge clk); #1;
         n++;
         if (ramMFC) got = 1'b1;
      end
      check({name, " mfc_latency"}, 32'(n), 32'(LAT));
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         check({name, " scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({name, " err"}, {31'd0, ramError}, {31'd0, e.err});
         if (e.chk_data) check({name, " data"}, ramDataOut, e.data);
      end
   endtask

   task automatic release_req(input string name);
      @(negedge clk);
      ramMFA = 1'b0;
      @(posedge clk); #1;
      check({name, " mfc_fall"}, {31'd0, ramMFC}, 32'd0);
      check({name, " err_fall"}, {31'd0, ramError}, 32'd0);
   endtask

   task automatic access(input string name, input logic rw, input logic [ADDR_W-1:0] addr,
                         input logic [1:0] size, input logic [31:0] din,
                         input logic [31:0] exp_data, input logic exp_err, input int hold);
      exp_t e;
      e.data = exp_data;
      e.err = exp_err;
      e.chk_data = (rw == RW_READ) || exp_err;
      sb.push_back(e);
      @(negedge clk);
      ramMFA = 1'b1; ramRW = rw; ramAddress = addr; ramDataSize = size; ramDataIn = din;
      @(posedge clk);
      wait_mfc(name);
      pop_check(name);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, " mfc_hold"}, {31'd0, ramMFC}, 32'd1);
      end
      release_req(name);
   endtask

   task automatic dword(input string name, input logic rw, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] w0, input logic [31:0] w1);
      exp_t e;
      e.err = 1'b0;
      e.chk_data = (rw == RW_READ);
      e.data = w0; sb.push_back(e);
      e.data = w1; sb.push_back(e);
      @(negedge clk);
      ramMFA = 1'b1; ramRW = rw; ramAddress = addr; ramDataSize = SIZE_DWORD; ramDataIn = w0;
      @(posedge clk);
      wait_mfc({name, " beat1"});
      pop_check({name, " beat1"});
      @(negedge clk);
      ramDataIn = w1;
      @(posedge clk); #1;
      check({name, " mfc_pulse_end"}, {31'd0, ramMFC}, 32'd0);
      wait_mfc({name, " beat2"});
      pop_check({name, " beat2"});
      release_req(name);
   endtask

   initial begin
      vecs[0]  = '{RW_WRITE, 9'h010, SIZE_WORD,  32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{RW_READ,  9'h010, SIZE_WORD,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{RW_READ,  9'h011, SIZE_BYTE,  32'h0,        32'h000000AD, 1'b0};
      vecs[3]  = '{RW_READ,  9'h012, SIZE_HALF,  32'h0,        32'h0000BEEF, 1'b0};
      vecs[4]  = '{RW_WRITE, 9'h013, SIZE_BYTE,  32'hFFFFFF55, 32'h0,        1'b0};
      vecs[5]  = '{RW_READ,  9'h010, SIZE_WORD,  32'h0,        32'hDEADBE55, 1'b0};
      vecs[6]  = '{RW_READ,  9'h012, SIZE_WORD,  32'h0,        32'h00000000, 1'b1};
      vecs[7]  = '{RW_WRITE, 9'h011, SIZE_HALF,  32'h0000FFFF, 32'h00000000, 1'b1};
      vecs[8]  = '{RW_READ,  9'h010, SIZE_WORD,  32'h0,        32'hDEADBE55, 1'b0};
      vecs[9]  = '{RW_READ,  9'h010, SIZE_HALF,  32'h0,        32'h0000DEAD, 1'b0};
      vecs[10] = '{RW_WRITE, 9'h100, SIZE_HALF,  32'h1234CAFE, 32'h0,        1'b0};
      vecs[11] = '{RW_READ,  9'h100, SIZE_HALF,  32'h0,        32'h0000CAFE, 1'b0};
      vecs[12] = '{RW_READ,  9'h101, SIZE_BYTE,  32'h0,        32'h000000FE, 1'b0};
      vecs[13] = '{RW_READ,  9'h014, SIZE_DWORD, 32'h0,        32'h00000000, 1'b1};

      reset = 1'b0; ramMFA = 1'b0; ramRW = RW_READ; ramAddress = '0;
      ramDataSize = SIZE_BYTE; ramDataIn = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset mfc", {31'd0, ramMFC}, 32'd0);
      check("reset err", {31'd0, ramError}, 32'd0);
      check("reset dout", ramDataOut, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 14; i++)
         access($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].size,
                vecs[i].din, vecs[i].exp_data, vecs[i].exp_err, 0);

      // Doubleword at the top of memory, then word-view read back.
      dword("dw_wr", RW_WRITE, 9'h1F8, 32'h11223344, 32'h55667788);
      dword("dw_rd", RW_READ,  9'h1F8, 32'h11223344, 32'h55667788);
      access("w1f8", RW_READ, 9'h1F8, SIZE_WORD, 32'h0, 32'h11223344, 1'b0, 0);
      access("w1fc", RW_READ, 9'h1FC, SIZE_WORD, 32'h0, 32'h55667788, 1'b0, 0);

      // Abort: request dropped one cycle after accept.
      @(negedge clk);
      ramMFA = 1'b1; ramRW = RW_WRITE; ramAddress = 9'h010; ramDataSize = SIZE_WORD;
      ramDataIn = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      ramMFA = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("abort no_mfc", {31'd0, ramMFC}, 32'd0);
      end
      access("abort readback", RW_READ, 9'h010, SIZE_WORD, 32'h0, 32'hDEADBE55, 1'b0, 0);

      // Reset during WAIT1 of a write.
      @(negedge clk);
      ramMFA = 1'b1; ramRW = RW_WRITE; ramAddress = 9'h010; ramDataSize = SIZE_WORD;
      ramDataIn = 32'hA5A5A5A5;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("rst_wait mfc", {31'd0, ramMFC}, 32'd0);
      check("rst_wait dout", ramDataOut, 32'd0);
      @(negedge clk);
      reset = 1'b1; ramMFA = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_wait idle_mfc", {31'd0, ramMFC}, 32'd0);
      end
      access("rst readback", RW_READ, 9'h010, SIZE_WORD, 32'h0, 32'hDEADBE55, 1'b0, 0);

      // Handshake hold: MFA kept high five cycles past MFC, then a fresh request.
      access("hold", RW_READ, 9'h011, SIZE_BYTE, 32'h0, 32'h000000AD, 1'b0, 5);
      access("after_hold", RW_READ, 9'h012, SIZE_HALF, 32'h0, 32'h0000BE55, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the CPU memory handshake. The control unit drives ramMFA, ramRW, ramAddress and ramDataSize; this block answers with ramMFC.
- Holds 512 bytes of byte-addressable, big-endian storage.
- Supports byte, halfword and word accesses, plus a two-beat doubleword access.
- Sits between the control unit and the datapath MDR/MAR. It is the responder end of the MFA/MFC protocol.

Parameters:
- LATENCY, 2, cycles from request accept to ramMFC rise per beat; legal range 1..15.
- MEM_BYTES, 512, storage size in bytes; must equal 2**ADDR_W.
- ADDR_W, 9, byte address width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- ramMFA  in  1  memory function activate (request); held high by the master until ramMFC is seen.
- ramRW  in  1  1 = read, 0 = write.
- ramAddress  in  ADDR_W  byte address of the first byte.
- ramDataSize  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
- ramDataIn  in  32  write data, right-justified.
- ramDataOut  out  32  read data, right-justified, zero-extended.
- ramMFC  out  1  memory function complete.
- ramError  out  1  misaligned request; valid while ramMFC = 1.

Behaviour:
- Reset (reset = 0 at a clk edge):
  - state becomes IDLE; ramMFC, ramError and ramDataOut become 0.
  - Storage is NOT cleared.
  - A reset during any state aborts the access; if the write commit edge has not occurred, no write is performed.
- States: IDLE, WAIT1, DONE1, WAIT2, DONE.
- IDLE: ramMFA = 1 at an edge accepts the request.
  - Latch ramRW, ramAddress, ramDataSize and ramDataIn.
  - Load the latency counter with LATENCY-1 and go to WAIT1.
- WAIT1 / WAIT2: the counter decrements each edge. At the edge where the counter is 0:
  - Read: capture data into ramDataOut.
  - Write: commit to storage.
  - Set ramMFC = 1.
  - ramMFC therefore rises exactly LATENCY edges after the accept edge.
- Abort: ramMFA = 0 during WAIT1 or WAIT2 returns to IDLE, with no MFC and no write.
- Alignment:
  - Halfword requires addr[0] = 0; word requires addr[1:0] = 0; doubleword requires addr[2:0] = 0.
  - A misaligned request runs the normal latency, then asserts ramMFC and ramError together, performs no write, drives ramDataOut = 0, and goes to DONE.
- Non-doubleword, or first beat in error: go to DONE.
  - Hold ramMFC (and ramError) high until ramMFA = 0 is sampled.
  - Then clear ramMFC and ramError and return to IDLE.
  - ramDataOut holds its last value.
- Doubleword:
  - Beat 1 transfers the word at addr, the high word. ramMFC is high for exactly one cycle (DONE1).
  - The master keeps ramMFA high. For writes it presents the second word on ramDataIn, which is latched at the DONE1 edge.
  - WAIT2 then runs LATENCY cycles for the word at addr+4. DONE follows.
  - Aligned addresses never wrap (maximum 504, so the second word is at 508).
  - ramMFA = 0 during DONE1 aborts beat 2 and returns to IDLE; beat 1 stays committed.
- Big-endian layout:
  - Byte at addr occupies bits [31:24] of a word access.
  - Halfword = {mem[a], mem[a+1]}.
  - Byte and halfword reads are zero-extended into bits [7:0] and [15:0].
  - Writes use only the low 8 or 16 bits of ramDataIn.
- ramMFA low while IDLE: outputs hold, no access.
- A new request is accepted only in IDLE, after the previous ramMFA has been seen low.

Decomposition:
- Shared package holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_DWORD encodings, also used by the control unit.
  - RW_READ/RW_WRITE constants.
  - The responder state enum.
- Sub-module ram_storage: a 512x8 array with one synchronous 32-bit big-endian read port and one write port with 4-bit byte enables. ram_responder holds the FSM, counter, alignment check and lane steering.

Test Plan:
- Word write then read: write 0xDEADBEEF to 0x010 (LATENCY = 2), then read the word at 0x010 → each ramMFC rises 2 edges after accept; read returns 0xDEADBEEF; ramError = 0.
- Byte and halfword: after the word above, byte read at 0x011 → 0x000000AD; halfword read at 0x012 → 0x0000BEEF; byte write of 0x55 to 0x013, then word read at 0x010 → 0xDEADBE55.
- Misaligned: word read at 0x012 → ramMFC = 1 and ramError = 1 after 2 edges; ramDataOut = 0; storage unchanged.
- Doubleword write then read at 0x1F8:
  - Write 0x11223344 / 0x55667788 → one-cycle MFC pulse, then a held MFC.
  - Read back → beat 1 gives 0x11223344, beat 2 gives 0x55667788.
  - Word reads at 0x1F8 and 0x1FC match.
- Abort and reset:
  - Word write with ramMFA dropped 1 cycle after accept → no MFC, memory unchanged.
  - reset = 0 asserted during WAIT1 → ramMFC = 0, state IDLE, no write.
- Handshake hold: ramMFA kept high for 5 cycles after MFC → ramMFC stays high throughout and falls on the edge after ramMFA = 0; the next request is accepted only afterwards.
